casex_match_table: RTL
======================

Name: casex_match_table

Overview:
- Programmable wildcard opcode matcher; generalises a fixed casex decoder into a run-time loaded table.
- Holds ENTRIES rows of pattern/mask/result.
- Each row's mask marks don't-care bits, with casex-style semantics on the item side.
- Streams opcodes through a 2-stage valid/ready pipeline and returns the lowest-index matching row's result, or DEFAULT_RES on a miss.
- Sits between instruction fetch and the ALU/memory control decode.

Parameters:
OP_W, 4, opcode width in bits (1..32)
ENTRIES, 8, number of table rows (2..32)
RES_W, 3, result payload width
IDX_W, $clog2(ENTRIES), row index width (derived; do not override)
DEFAULT_RES, 0, result returned when no valid row matches

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
cfg_we  in  1  write one table row this cycle
cfg_idx  in  IDX_W  row to write; writes to rows >= ENTRIES are ignored
cfg_pattern  in  OP_W  compare value
cfg_mask  in  OP_W  1 = don't-care bit
cfg_result  in  RES_W  payload returned on match
cfg_en  in  1  row valid bit written with the row
in_valid  in  1  opcode presented
in_ready  out  1  pipeline can accept
in_opcode  in  OP_W  opcode to decode
out_valid  out  1  result available
out_ready  in  1  consumer accepts
out_result  out  RES_W  matched payload or DEFAULT_RES
out_hit  out  1  1 = some valid row matched
out_index  out  IDX_W  matching row index (0 on miss)
miss_count  out  16  miss statistics (see Optional Feature)

Behaviour:
- Reset (async assert, sync release):
  - all rows cfg_en=0 and pattern/mask/result=0.
  - Both pipeline stage valids=0, out_valid=0, out_result=0, out_hit=0, out_index=0, miss_count=0.
  - Reset mid-transaction discards all in-flight opcodes with no output.
- Match rule: row i hits when en[i] && ((in_opcode ^ pattern[i]) & ~mask[i]) == 0. X/Z on in_opcode is not treated as wildcard; only the mask is.
- Stage 1 (S1): on in_valid && in_ready, registers the ENTRIES-bit hit vector, computed against the table contents before any same-cycle write.
- Stage 2 (S2 = output registers): priority-encodes the S1 vector.
  - Lowest set index wins: out_hit=1, out_index=i, out_result=result[i].
  - None set: out_hit=0, out_index=0, out_result=DEFAULT_RES.
- Result payload is read from the table at S2 load time. A row write landing between S1 and S2 therefore updates only the result field seen. The bench must accept this; the implementation shall not hide it.
- Latency: an opcode accepted in cycle N gives out_valid in cycle N+2 when not stalled. Throughput is 1/cycle.
- Handshake:
  - S2 holds while out_valid && !out_ready.
  - S1 advances when S2 is empty or being drained.
  - in_ready = !s1_valid || s1_advances (combinational from out_ready; no skid buffer).
  - out_* hold stable while out_valid && !out_ready.
- Config writes:
  - Accepted every cycle regardless of handshake state; effective the next cycle.
  - Multiple rows may share a pattern; priority resolves the overlap.
  - cfg_idx out of range: no effect.
- All rows disabled: every lookup misses.
- mask all-ones with en=1 matches every opcode. Used as the catch-all in the highest row.

Optional Feature:
- Macro CASEX_MATCH_MISS_STATS_EN.
- Defined:
  - miss_count increments by 1 each time S2 hands off a miss (out_valid && out_ready && !out_hit).
  - Saturates at 16'hFFFF; cleared only by rst.
- Undefined: miss_count tied to 16'h0000 and no counter logic is synthesised; all other behaviour is identical.

Test Plan:
- Load rows as follows, then stream opcodes 0..15 back-to-back with out_ready=1:
  - row0 pat 0000 mask 0001 res 0
  - row1 pat 0010 mask 0001 res 1
  - row2 pat 0100 mask 0011 res 2
  - row3 pat 1000 mask 0111 res 3
  - Required: results 0,0,1,1,2,2,2,2,3×8, all out_hit=1, first out_valid 2 cycles after first accept.
- Overlap: row1 = pat 0000 mask 1111 res 5, row4 = pat 0011 mask 0000 res 6; opcode 0011 -> out_index 1, out_result 5.
- Miss: only row0 enabled (pat 0000 mask 0000); opcode 1010 -> out_hit 0, out_result DEFAULT_RES, out_index 0. With the macro, 3 misses give miss_count 3.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 opcodes accepted, in_ready=0, out_* stable. Release -> remaining results in order, none lost or duplicated.
- Same-cycle write: lookup 0101 while writing row2 en=0 -> uses old table (hit row2). The next 0101 misses.
- Async rst asserted with both stages full -> out_valid drops immediately; after release no stale output, and all rows miss until reloaded.

Source files
------------

// File: rtl/casex_match_table_if.sv
// Configuration, opcode-stream and statistics signals of casex_match_table.
// The master drives table writes and opcodes; the slave is the matcher.
interface casex_match_table_if #(
    parameter int OP_W    = 4,
    parameter int ENTRIES = 8,
    parameter int RES_W   = 3,
    parameter int IDX_W   = $clog2(ENTRIES)
);
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_idx;
    logic [OP_W-1:0]  cfg_pattern;
    logic [OP_W-1:0]  cfg_mask;
    logic [RES_W-1:0] cfg_result;
    logic             cfg_en;

    logic             in_valid;
    logic             in_ready;
    logic [OP_W-1:0]  in_opcode;

    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] out_result;
    logic             out_hit;
    logic [IDX_W-1:0] out_index;

    logic [15:0]      miss_count;

    modport master (
        output cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_result, cfg_en,
        output in_valid, in_opcode, out_ready,
        input  in_ready, out_valid, out_result, out_hit, out_index, miss_count
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_pattern, cfg_mask, cfg_result, cfg_en,
        input  in_valid, in_opcode, out_ready,
        output in_ready, out_valid, out_result, out_hit, out_index, miss_count
    );
endinterface

// File: rtl/casex_match_table.sv
// Run-time loaded wildcard opcode matcher with a 2-stage valid/ready pipeline.
// Optional miss statistics counter enabled by defining CASEX_MATCH_MISS_STATS_EN.
module casex_match_table #(
    parameter int               OP_W        = 4,
    parameter int               ENTRIES     = 8,
    parameter int               RES_W       = 3,
    parameter int               IDX_W       = $clog2(ENTRIES),
    parameter logic [RES_W-1:0] DEFAULT_RES = {RES_W{1'b0}}
) (
    input  logic                clk,
    input  logic                rst,
    casex_match_table_if.slave  bus
);
    logic [OP_W-1:0]    r_pat  [ENTRIES];
    logic [OP_W-1:0]    r_mask [ENTRIES];
    logic [RES_W-1:0]   r_res  [ENTRIES];
    logic [ENTRIES-1:0] r_en;

    logic               r_s1_valid;
    logic [ENTRIES-1:0] r_s1_hit;

    logic               r_out_valid;
    logic               r_out_hit;
    logic [IDX_W-1:0]   r_out_index;
    logic [RES_W-1:0]   r_out_result;

    logic [ENTRIES-1:0] w_hit;
    logic               w_cfg_in_range;
    logic               w_s2_load;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_enc_hit;
    logic [IDX_W-1:0]   w_enc_idx;
    logic [RES_W-1:0]   w_enc_res;

    // Table row storage; a write becomes visible to lookups on the next cycle.
    assign w_cfg_in_range = (int'(bus.cfg_idx) < ENTRIES);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_pat[i]  <= {OP_W{1'b0}};
                r_mask[i] <= {OP_W{1'b0}};
                r_res[i]  <= {RES_W{1'b0}};
            end
            r_en <= {ENTRIES{1'b0}};
        end else if (bus.cfg_we && w_cfg_in_range) begin
            r_pat[bus.cfg_idx]  <= bus.cfg_pattern;
            r_mask[bus.cfg_idx] <= bus.cfg_mask;
            r_res[bus.cfg_idx]  <= bus.cfg_result;
            r_en[bus.cfg_idx]   <= bus.cfg_en;
        end
    end

    // Per-row compare; an X on the opcode never acts as a wildcard, only the mask does.
    always_comb begin
        w_hit = {ENTRIES{1'b0}};
        for (int i = 0; i < ENTRIES; i++) begin
            w_hit[i] = r_en[i] &&
                       (((bus.in_opcode ^ r_pat[i]) & ~r_mask[i]) == {OP_W{1'b0}});
        end
    end

    // Handshake: S1 moves into S2 whenever S2 is empty or being drained.
    assign w_s2_load  = r_s1_valid && (!r_out_valid || bus.out_ready);
    assign w_in_ready = !r_s1_valid || w_s2_load;
    assign w_accept   = bus.in_valid && w_in_ready;

    // Stage 1: capture the hit vector against the pre-write table contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_hit   <= {ENTRIES{1'b0}};
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_hit   <= w_hit;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Lowest-index priority encode; scanning downward lets the lowest hit win.
    always_comb begin
        w_enc_hit = 1'b0;
        w_enc_idx = {IDX_W{1'b0}};
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            w_enc_hit = r_s1_hit[i] ? 1'b1 : w_enc_hit;
            w_enc_idx = r_s1_hit[i] ? IDX_W'(i) : w_enc_idx;
        end
        w_enc_res = w_enc_hit ? r_res[w_enc_idx] : DEFAULT_RES;
    end

    // Stage 2 output registers; payload is read from the table at load time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_hit    <= 1'b0;
            r_out_index  <= {IDX_W{1'b0}};
            r_out_result <= {RES_W{1'b0}};
        end else if (w_s2_load) begin
            r_out_valid  <= 1'b1;
            r_out_hit    <= w_enc_hit;
            r_out_index  <= w_enc_idx;
            r_out_result <= w_enc_res;
        end else if (bus.out_ready) begin
            r_out_valid  <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_hit    = r_out_hit;
    assign bus.out_index  = r_out_index;
    assign bus.out_result = r_out_result;

`ifdef CASEX_MATCH_MISS_STATS_EN
    logic [15:0] r_miss_cnt;

    // Saturating count of misses handed to the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_miss_cnt <= 16'h0000;
        end else if (r_out_valid && bus.out_ready && !r_out_hit &&
                     (r_miss_cnt != 16'hFFFF)) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign bus.miss_count = r_miss_cnt;
`else
    assign bus.miss_count = 16'h0000;
`endif
endmodule
